dbus_sram_responder: RTL

- Responder (slave) end of the data-bus protocol (dbus_req_t / dbus_resp_t) driven by the memory unit.
- Holds a word-addressed 64-bit SRAM model.
- Accepts one read or write request at a time and answers after a programmable wait.
- Used as the data-memory stand-in for core simulation and as the template for a real cache/bus bridge.

---
 rtl/dbus_sram_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_responder (plus package dbus_pkg)
// Purpose  : Responder end of the data bus. Holds a word-addressed 64-bit
//            SRAM model, accepts one read/write request at a time and answers
//            after LATENCY wait cycles with a one-cycle addr_ok/data_ok pulse.
//            The response always carries the pre-write word value.
// Ports    : clk   - system clock, all state on rising edge
//            rst   - asynchronous reset, active low
//            dreq  - request  {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}
//            dresp - response {addr_ok, data_ok, data[63:0]}
//            busy  - high while a request is held (WAIT or RESP)
// Revision : 1.0 - initial release
// ============================================================================

package dbus_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_sram_responder #(
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  dbus_pkg::dbus_req_t  dreq,
   output dbus_pkg::dbus_resp_t dresp,
   output logic                 busy
);
   import dbus_pkg::*;

   localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [63:0] C_SPAN     = 64'(DEPTH) * 64'd8;
   localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [63:0]      r_addr;
   logic [7:0]       r_strobe;
   logic [63:0]      r_wdata;
   dbus_resp_t       r_resp;
   logic             r_busy;
   logic [63:0]      r_mem [DEPTH];

   logic [63:0]      w_addr;
   logic [7:0]       w_strobe;
   logic [63:0]      w_wdata;
   logic [63:0]      w_off;
   logic             w_in_range;
   logic [IDX_W-1:0] w_idx;
   logic             w_enter_resp;
   logic             w_we;
   logic             w_unused;

   // With LATENCY=0 the RESP entry happens on the accepting edge itself, so
   // the live request must be used there; otherwise the latched copy.
   assign w_addr   = (r_state == S_IDLE) ? dreq.addr   : r_addr;
   assign w_strobe = (r_state == S_IDLE) ? dreq.strobe : r_strobe;
   assign w_wdata  = (r_state == S_IDLE) ? dreq.data   : r_wdata;

   // Unsigned 64-bit difference: addresses below the base wrap to huge
   // offsets and fall out of range naturally.
   assign w_off      = w_addr - BASE_ADDR;
   assign w_in_range = (w_off < C_SPAN);
   assign w_idx      = w_off[IDX_W+2:3];

   assign w_enter_resp = ((r_state == S_IDLE) && dreq.valid && (LATENCY == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == '0));

   // Gated by rst so a request dropped by reset never commits its write.
   assign w_we = rst && w_enter_resp && w_in_range && (w_strobe != 8'h00);

   // size is informational only; strobe selects the bytes.
   assign w_unused = ^{dreq.size, w_off[2:0], w_off[63:IDX_W+3]};

   // Array has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int i = 0; i < 8; i++) begin
            if (w_strobe[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_strobe <= '0;
         r_wdata  <= '0;
         r_resp   <= '0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (dreq.valid) begin
                  r_addr   <= dreq.addr;
                  r_strobe <= dreq.strobe;
                  r_wdata  <= dreq.data;
                  r_busy   <= 1'b1;
                  if (LATENCY == 0) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= C_CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               r_state        <= S_IDLE;
               r_resp.addr_ok <= 1'b0;
               r_resp.data_ok <= 1'b0;
               r_busy         <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase

         // Response data is the pre-write value: the read sees r_mem before
         // the same-edge write lands.
         if (w_enter_resp) begin
            r_resp.addr_ok <= 1'b1;
            r_resp.data_ok <= 1'b1;
            r_resp.data    <= w_in_range ? r_mem[w_idx] : 64'h0;
         end
      end
   end

   assign dresp = r_resp;
   assign busy  = r_busy;

endmodule
`default_nettype wire
